// File: rtl/mips_pkg.sv
// Shared types and constants for the memory arbiter.
package mips_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Registered memory command presented on the m_* port.
  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] wdata;
    logic            read;
    logic            write;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_reg.sv
// Enable-loaded register with synchronous active-low clear.
module mem_arbiter_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;

  // Load on enable, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage loads/stores.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [XLEN-1:0] inst_adr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] data_adr,
  input  logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] data_in,
  output logic            stall,
  output logic [XLEN-1:0] m_adr,
  output logic [XLEN-1:0] m_wdata,
  output logic            m_read,
  output logic            m_write,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack,
  output logic            err
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  arb_state_e       state_q, state_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fpend_q, fpend_d;

  logic             dbuf_en, ibuf_en;
  logic [XLEN-1:0]  dbuf_d, ibuf_d;
  logic [XLEN-1:0]  dbuf_q, ibuf_q;

  logic             active;
  logic             timeout;
  logic             acc_end;

  // Access completes on ack, or aborts when the wait budget is used up.
  assign active  = cmd_q.read | cmd_q.write;
  assign timeout = active & ~m_ack & (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign acc_end = active & (m_ack | timeout);

  // State and command registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fpend_q <= fpend_d;
    end
  end

  // Next-state, command launch and buffer load control.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fpend_d = fpend_q;
    dbuf_en = 1'b0;
    ibuf_en = 1'b0;
    dbuf_d  = timeout ? '0 : m_rdata;
    ibuf_d  = timeout ? '0 : m_rdata;

    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          // A read+write conflict is executed as a store and flagged.
          state_d     = D_ACC;
          cmd_d.adr   = data_adr;
          cmd_d.wdata = data_out;
          cmd_d.read  = mem_read & ~mem_write;
          cmd_d.write = mem_write;
          cnt_d       = '0;
          fpend_d     = inst_req;
          if (mem_read & mem_write) err_d = 1'b1;
        end else if (inst_req) begin
          state_d     = I_ACC;
          cmd_d.adr   = inst_adr;
          cmd_d.wdata = '0;
          cmd_d.read  = 1'b1;
          cmd_d.write = 1'b0;
          cnt_d       = '0;
          fpend_d     = 1'b0;
        end
      end

      D_ACC: begin
        if (acc_end) begin
          dbuf_en     = cmd_q.read;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          if (timeout) err_d = 1'b1;
          state_d     = fpend_q ? I_ACC : DONE;
          fpend_d     = 1'b0;
        end else if (active) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      I_ACC: begin
        if (!active) begin
          // Strobe-low gap after a data access; launch the fetch now.
          cmd_d.adr   = inst_adr;
          cmd_d.wdata = '0;
          cmd_d.read  = 1'b1;
          cmd_d.write = 1'b0;
          cnt_d       = '0;
        end else if (acc_end) begin
          ibuf_en     = 1'b1;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          if (timeout) err_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mem_arbiter_reg #(.W(XLEN)) u_data_buf (
    .clk  (clk),
    .rst  (rst),
    .en_i (dbuf_en),
    .d_i  (dbuf_d),
    .q_o  (dbuf_q)
  );

  mem_arbiter_reg #(.W(XLEN)) u_inst_buf (
    .clk  (clk),
    .rst  (rst),
    .en_i (ibuf_en),
    .d_i  (ibuf_d),
    .q_o  (ibuf_q)
  );

  // Pipeline runs only in DONE, or in IDLE when nothing is requested.
  assign stall   = (state_q == IDLE) ? (inst_req | mem_read | mem_write)
                                     : (state_q != DONE);
  assign inst    = ibuf_q;
  assign data_in = dbuf_q;
  assign m_adr   = cmd_q.adr;
  assign m_wdata = cmd_q.wdata;
  assign m_read  = cmd_q.read;
  assign m_write = cmd_q.write;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_adr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] data_out;
  logic [31:0] inst;
  logic [31:0] data_in;
  logic        stall;
  logic [31:0] m_adr;
  logic [31:0] m_wdata;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        err;

  int n_checks;
  int n_fail;

  logic [31:0] exp_inst;
  logic [31:0] exp_data;
  logic        exp_err;

  mem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_adr  (inst_adr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_adr  (data_adr),
    .data_out  (data_out),
    .inst      (inst),
    .data_in   (data_in),
    .stall     (stall),
    .m_adr     (m_adr),
    .m_wdata   (m_wdata),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // One memory access as the memory sees it; called at a falling edge.
  task automatic do_access(input logic [31:0] adr, input logic [31:0] wd, input logic wr,
                           input int dly, input logic [31:0] rd,
                           output logic [31:0] val, output logic tmo);
    val = 32'h0;
    tmo = 1'b1;
    for (int k = 0; k < MAXW; k++) begin
      #1;
      check("m_adr", m_adr, adr);
      if (wr) check("m_wdata", m_wdata, wd);
      check("m_read", 32'(m_read), 32'(!wr));
      check("m_write", 32'(m_write), 32'(wr));
      check("busy_stall", 32'(stall), 32'd1);
      if (k == dly) begin
        m_ack   = 1'b1;
        m_rdata = rd;
      end
      @(negedge clk);
      m_ack   = 1'b0;
      m_rdata = $urandom;
      if (k == dly) begin
        val = rd;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // One pipeline request held until the pipeline is released; starts and ends at a falling edge in IDLE.
  task automatic run_txn(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                         input logic [31:0] da, input logic [31:0] dout,
                         input int dly_d, input int dly_i,
                         input logic [31:0] rd_d, input logic [31:0] rd_i,
                         input logic ack_in_done);
    logic [31:0] val;
    logic        tmo;
    inst_req  = ir;
    inst_adr  = ia;
    mem_read  = mr;
    mem_write = mw;
    data_adr  = da;
    data_out  = dout;
    #1;
    check("idle_stall", 32'(stall), 32'(ir | mr | mw));
    @(negedge clk);
    if (!(ir | mr | mw)) return;
    if (mr | mw) begin
      do_access(da, dout, mw, dly_d, rd_d, val, tmo);
      if (mr & mw) exp_err = 1'b1;
      if (tmo) exp_err = 1'b1;
      if (!mw) exp_data = val;
      if (ir) begin
        #1;
        check("gap_m_read", 32'(m_read), 32'd0);
        check("gap_m_write", 32'(m_write), 32'd0);
        check("gap_stall", 32'(stall), 32'd1);
        @(negedge clk);
      end
    end
    if (ir) begin
      do_access(ia, 32'h0, 1'b0, dly_i, rd_i, val, tmo);
      exp_inst = val;
      if (tmo) exp_err = 1'b1;
    end
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_m_read", 32'(m_read), 32'd0);
    check("done_m_write", 32'(m_write), 32'd0);
    check("done_inst", inst, exp_inst);
    check("done_data_in", data_in, exp_data);
    check("done_err", 32'(err), 32'(exp_err));
    if (ack_in_done) begin
      m_ack   = 1'b1;
      m_rdata = $urandom;
    end
    @(negedge clk);
    m_ack     = 1'b0;
    inst_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("idle_stall_none", 32'(stall), 32'd0);
    if (ack_in_done) begin
      check("ignored_ack_inst", inst, exp_inst);
      check("ignored_ack_data", data_in, exp_data);
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_txn(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 9) < 3), $urandom, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom,
              ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_inst  = 32'h0;
    exp_data  = 32'h0;
    exp_err   = 1'b0;
    rst       = 1'b0;
    inst_req  = 1'b0;
    inst_adr  = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    data_adr  = 32'h0;
    data_out  = 32'h0;
    m_rdata   = 32'h0;
    m_ack     = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // fetch only, ack two cycles after strobe
    run_txn(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, 2, 32'h0, 32'h8C010004, 1'b0);
    // minimum latency fetch
    run_txn(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 32'h0, 32'h12345678, 1'b0);
    // load plus fetch
    run_txn(1'b1, 32'h48, 1'b1, 1'b0, 32'h100, 32'h0, 1, 0, 32'hCAFEF00D, 32'h01020304, 1'b0);
    // store, data buffer unchanged
    run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 2, 0, 32'h55555555, 32'h0, 1'b0);
    // no request
    run_txn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0);
    // stray ack in DONE is ignored
    run_txn(1'b1, 32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 32'hA5A5A5A5, 1'b1);
    // fetch timeout: inst cleared, err set
    run_txn(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 0, 9, 32'h0, 32'h77777777, 1'b0);
    // read/write conflict executes as store
    run_txn(1'b1, 32'h54, 1'b1, 1'b1, 32'h300, 32'h0BADC0DE, 0, 0, 32'h99999999, 32'h31415926, 1'b0);

    run_random(250);

    // reset in the middle of a data access
    mem_read = 1'b1;
    data_adr = 32'h100;
    #1;
    @(negedge clk);
    #1;
    check("pre_rst_m_read", 32'(m_read), 32'd1);
    rst      = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_m_read", 32'(m_read), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_inst", inst, 32'h0);
    check("midrst_data_in", data_in, 32'h0);
    rst      = 1'b1;
    exp_inst = 32'h0;
    exp_data = 32'h0;
    exp_err  = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 32'h60, 1'b1, 1'b0, 32'h104, 32'h0, 0, 3, 32'h0000BEEF, 32'h00C0FFEE, 1'b0);
    run_random(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum cycles waited for m_ack per access before abort.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port inst_req, input, 1, pipeline needs an instruction fetch this cycle.
REQ-005 SHALL have port inst_adr, input, 32, fetch address (PC).
REQ-006 SHALL have port mem_read, input, 1, MEM-stage load request.
REQ-007 SHALL have port mem_write, input, 1, MEM-stage store request.
REQ-008 SHALL have port data_adr, input, 32, load/store address.
REQ-009 SHALL have port data_out, input, 32, store data from the datapath.
REQ-010 SHALL have port inst, output, 32, fetched instruction to IF.
REQ-011 SHALL have port data_in, output, 32, load data to MEM.
REQ-012 SHALL have port stall, output, 1, freezes PC and all pipeline registers while high.
REQ-013 SHALL have port m_adr, output, 32, memory address.
REQ-014 SHALL have port m_wdata, output, 32, memory write data.
REQ-015 SHALL have port m_read, output, 1, memory read strobe.
REQ-016 SHALL have port m_write, output, 1, memory write strobe.
REQ-017 SHALL have port m_rdata, input, 32, memory read data, valid with m_ack.
REQ-018 SHALL have port m_ack, input, 1, memory completion, single-cycle pulse.
REQ-019 SHALL have port err, output, 1, sticky fault flag.

Function
REQ-020 SHALL implement FSM states IDLE, D_ACC, I_ACC, DONE.
REQ-021 SHALL, in IDLE, sample requests: data request pending -> D_ACC; else inst_req -> I_ACC; else stay IDLE.
REQ-022 SHALL give data accesses priority over fetch: the MEM-stage instruction is older.
REQ-023 SHALL, on entering D_ACC or I_ACC, register address, write data and operation; m_adr, m_wdata, m_read and m_write SHALL be registered and held stable until m_ack or abort.
REQ-024 SHALL, on m_ack in D_ACC, capture m_rdata into the data buffer (loads only), then go to I_ACC if the inst_req sampled in IDLE was set, else DONE.
REQ-025 SHALL, on m_ack in I_ACC, capture m_rdata into the instruction buffer and go to DONE.
REQ-026 SHALL drop the strobes in the cycle after m_ack; back-to-back D_ACC->I_ACC SHALL have one strobe-low cycle between accesses.
REQ-027 SHALL drive stall=0 only in DONE; DONE lasts exactly one cycle, then goes to IDLE.
REQ-028 SHALL drive stall=1 in IDLE whenever any request is present, and in D_ACC/I_ACC; in IDLE with no requests, stall=0.
REQ-029 SHALL drive inst and data_in continuously from their buffers.
REQ-030 SHALL ignore m_ack in IDLE and DONE.
REQ-031 SHALL, when mem_read and mem_write are both high, perform the write, treat the request as a store, and set err.
REQ-032 SHALL run a wait counter that clears on entering D_ACC/I_ACC; at MAX_WAIT cycles without m_ack it SHALL abort: strobes low, target buffer loaded with 0, err set, proceed as if acked.
REQ-033 SHALL hold err until reset.
REQ-034 SHALL produce minimum latency, for a fetch with m_ack one cycle after the strobe, of IDLE->I_ACC->I_ACC(ack)->DONE: stall low on cycle 4.

Reset
REQ-035 SHALL, while rst=0 at a clock edge, enter IDLE and clear the buffers, counter, m_adr, m_wdata, m_read, m_write and err; stall SHALL then be 0 with no requests present.
REQ-036 SHALL abandon an in-flight access on reset mid-access; strobes SHALL be low the cycle after reset.

Structure
REQ-037 SHALL place the state encoding (2-bit IDLE=0, D_ACC=1, I_ACC=2, DONE=3) and the MAX_WAIT default in a shared package (mips_pkg).
REQ-038 SHALL use the existing register module for the two 32-bit buffers; no other sub-module.

Verification
REQ-039 Fetch only: inst_req=1, inst_adr=0x40, m_ack 2 cycles after m_read, m_rdata=0x8C010004 -> m_adr=0x40, inst=0x8C010004, stall low exactly one cycle.
REQ-040 Load plus fetch: mem_read=1, data_adr=0x100, inst_req=1 -> data access first (m_adr=0x100), then fetch; data_in and inst valid in the same DONE cycle.
REQ-041 Store: mem_write=1, data_out=0xDEADBEEF -> m_write=1, m_wdata=0xDEADBEEF; data buffer unchanged.
REQ-042 Timeout: MAX_WAIT=4, no m_ack -> strobes drop after 4 cycles, err=1, inst=0, DONE reached.
REQ-043 Conflict: mem_read=mem_write=1 -> write performed, err=1.
REQ-044 Reset mid-access: rst=0 during D_ACC -> next cycle IDLE, m_read=0, err=0, stall=0 with no requests.
